// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - byte-stream command frame parser: SYNC, ID, LEN, payload, CKSUM
// Publishes good frames on o_cmd_*, flags checksum/length/timeout errors with a saturating count.
module uart_cmd_parser #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 8,
  parameter int         TIMEOUT_CLKS = 10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_cmd_valid,
  output logic [7:0]  o_cmd_id,
  output logic [3:0]  o_cmd_len,
  output logic [63:0] o_cmd_payload,
  output logic        o_cksum_err,
  output logic        o_len_err,
  output logic        o_timeout_err,
  output logic [7:0]  o_err_count,
  output logic        o_busy
);

  typedef enum logic [2:0] {IDLE, GET_ID, GET_LEN, GET_PAYLOAD, GET_CKSUM} state_t;

  localparam int GW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;

  state_t        state;
  logic [GW-1:0] gap_cnt;
  logic [7:0]    sh_id;
  logic [3:0]    sh_len;
  logic [63:0]   sh_payload;
  logic [2:0]    idx;
  logic [7:0]    sum;

  logic len_bad;
  logic ck_bad;
  logic gap_expired;
  logic any_err;

  // A strobe always wins over an expiring gap, so a byte on the last legal cycle is kept.
  assign gap_expired = (state != IDLE) && !i_rx_valid && (gap_cnt == GW'(TIMEOUT_CLKS - 1));
  assign len_bad     = i_rx_valid && (state == GET_LEN) && (i_rx_data > 8'(MAX_LEN));
  assign ck_bad      = i_rx_valid && (state == GET_CKSUM) && (i_rx_data != sum);
  assign any_err     = len_bad || ck_bad || gap_expired;
  assign o_busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      gap_cnt       <= '0;
      sh_id         <= '0;
      sh_len        <= '0;
      sh_payload    <= '0;
      idx           <= '0;
      sum           <= '0;
      o_cmd_valid   <= 1'b0;
      o_cmd_id      <= '0;
      o_cmd_len     <= '0;
      o_cmd_payload <= '0;
      o_cksum_err   <= 1'b0;
      o_len_err     <= 1'b0;
      o_timeout_err <= 1'b0;
      o_err_count   <= '0;
    end else begin
      o_cmd_valid   <= 1'b0;
      o_cksum_err   <= ck_bad;
      o_len_err     <= len_bad;
      o_timeout_err <= gap_expired;
      if (any_err && (o_err_count != 8'hFF))
        o_err_count <= o_err_count + 8'd1;

      if ((state == IDLE) || i_rx_valid)
        gap_cnt <= '0;
      else
        gap_cnt <= gap_cnt + GW'(1);

      if (gap_expired) begin
        state <= IDLE;
      end else if (i_rx_valid) begin
        case (state)
          IDLE: begin
            if (i_rx_data == SYNC_BYTE) begin
              state      <= GET_ID;
              sh_payload <= '0;
              idx        <= '0;
            end
          end
          GET_ID: begin
            sh_id <= i_rx_data;
            sum   <= i_rx_data;
            state <= GET_LEN;
          end
          GET_LEN: begin
            sh_len <= i_rx_data[3:0];
            sum    <= sum + i_rx_data;
            if (len_bad)
              state <= IDLE;
            else if (i_rx_data == 8'd0)
              state <= GET_CKSUM;
            else
              state <= GET_PAYLOAD;
          end
          GET_PAYLOAD: begin
            sh_payload[{idx, 3'b000} +: 8] <= i_rx_data;
            sum <= sum + i_rx_data;
            idx <= idx + 3'd1;
            if ({1'b0, idx} == (sh_len - 4'd1))
              state <= GET_CKSUM;
          end
          GET_CKSUM: begin
            state <= IDLE;
            if (!ck_bad) begin
              o_cmd_valid   <= 1'b1;
              o_cmd_id      <= sh_id;
              o_cmd_len     <= sh_len;
              o_cmd_payload <= sh_payload;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - self-checking bench for uart_cmd_parser
module tb_uart_cmd_parser;

  logic        clk;
  logic        rst;
  logic        i_rx_valid;
  logic [7:0]  i_rx_data;
  logic        o_cmd_valid;
  logic [7:0]  o_cmd_id;
  logic [3:0]  o_cmd_len;
  logic [63:0] o_cmd_payload;
  logic        o_cksum_err;
  logic        o_len_err;
  logic        o_timeout_err;
  logic [7:0]  o_err_count;
  logic        o_busy;

  int checks   = 0;
  int failures = 0;
  int cnt_valid = 0;
  int cnt_ck    = 0;
  int cnt_len   = 0;
  int cnt_tmo   = 0;

  uart_cmd_parser #(
    .SYNC_BYTE   (8'hA5),
    .MAX_LEN     (8),
    .TIMEOUT_CLKS(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rx_valid   (i_rx_valid),
    .i_rx_data    (i_rx_data),
    .o_cmd_valid  (o_cmd_valid),
    .o_cmd_id     (o_cmd_id),
    .o_cmd_len    (o_cmd_len),
    .o_cmd_payload(o_cmd_payload),
    .o_cksum_err  (o_cksum_err),
    .o_len_err    (o_len_err),
    .o_timeout_err(o_timeout_err),
    .o_err_count  (o_err_count),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_cmd_valid)   cnt_valid++;
    if (o_cksum_err)   cnt_ck++;
    if (o_len_err)     cnt_len++;
    if (o_timeout_err) cnt_tmo++;
  end

  // Bytes are packed with the first byte on the wire in bits [7:0].
  typedef struct {
    logic [95:0] bytes;
    int          n;
    logic        ev;
    logic        ec;
    logic        el;
    logic [7:0]  id;
    logic [3:0]  len;
    logic [63:0] pl;
    logic [7:0]  errs;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [95:0] b, input int n, input logic ev, input logic ec,
                     input logic el, input logic [7:0] id, input logic [3:0] len,
                     input logic [63:0] pl, input logic [7:0] errs);
    vec_t v;
    v.bytes = b; v.n = n; v.ev = ev; v.ec = ec; v.el = el;
    v.id = id; v.len = len; v.pl = pl; v.errs = errs;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    @(posedge clk);
    #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [95:0] b, input int n);
    for (int i = 0; i < n; i++) send(b[i*8 +: 8]);
  endtask

  int base;

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_valid", 64'(o_cmd_valid), 64'd0);
    check("rst_payload", o_cmd_payload, 64'd0);
    check("rst_errcnt", 64'(o_err_count), 64'd0);
    check("rst_pulses", 64'({o_cksum_err, o_len_err, o_timeout_err}), 64'd0);
    rst = 1'b0;

    add(96'h15_02_01_02_10_A5,             6, 1, 0, 0, 8'h10, 4'd2, 64'h0201, 8'd0);
    add(96'h20_00_20_A5,                   4, 1, 0, 0, 8'h20, 4'd0, 64'h0, 8'd0);
    add(96'h00_FF_01_10_A5,                5, 0, 1, 0, 8'h20, 4'd0, 64'h0, 8'd1);
    add(96'h09_10_A5,                      3, 0, 0, 1, 8'h20, 4'd0, 64'h0, 8'd2);
    add(96'h30_00_30_A5,                   4, 1, 0, 0, 8'h30, 4'd0, 64'h0, 8'd2);
    add(96'h5A_FF_00,                      3, 0, 0, 0, 8'h30, 4'd0, 64'h0, 8'd2);
    add(96'hAE_88_77_66_55_44_33_22_11_08_42_A5, 12, 1, 0, 0, 8'h42, 4'd8,
        64'h8877665544332211, 8'd2);
    add(96'h4D_A5_A5_02_01_A5,             6, 1, 0, 0, 8'h01, 4'd2, 64'hA5A5, 8'd2);
    add(96'h85_7F_01_05_A5,                5, 1, 0, 0, 8'h05, 4'd1, 64'h7F, 8'd2);
    add(96'hFF_10_A5,                      3, 0, 0, 1, 8'h05, 4'd1, 64'h7F, 8'd3);

    // Rows are sent back to back, so each frame starts the cycle after the previous one ends.
    for (int r = 0; r < vecs.size(); r++) begin
      send_frame(vecs[r].bytes, vecs[r].n);
      check($sformatf("row%0d valid", r), 64'(o_cmd_valid), 64'(vecs[r].ev));
      check($sformatf("row%0d cksum_err", r), 64'(o_cksum_err), 64'(vecs[r].ec));
      check($sformatf("row%0d len_err", r), 64'(o_len_err), 64'(vecs[r].el));
      check($sformatf("row%0d timeout_err", r), 64'(o_timeout_err), 64'd0);
      check($sformatf("row%0d id", r), 64'(o_cmd_id), 64'(vecs[r].id));
      check($sformatf("row%0d len", r), 64'(o_cmd_len), 64'(vecs[r].len));
      check($sformatf("row%0d payload", r), o_cmd_payload, vecs[r].pl);
      check($sformatf("row%0d err_count", r), 64'(o_err_count), 64'(vecs[r].errs));
      check($sformatf("row%0d busy", r), 64'(o_busy), 64'd0);
    end
    @(negedge clk);
    #1;
    check("tally_valid", 64'(cnt_valid), 64'd6);
    check("tally_cksum", 64'(cnt_ck), 64'd1);
    check("tally_len", 64'(cnt_len), 64'd2);
    check("tally_timeout", 64'(cnt_tmo), 64'd0);
    @(posedge clk);
    #1;

    // Timeout after 16 silent cycles inside a frame.
    send(8'hA5);
    send(8'h10);
    check("tmo_busy_before", 64'(o_busy), 64'd1);
    repeat (20) @(posedge clk);
    #1;
    check("tmo_once", 64'(cnt_tmo), 64'd1);
    check("tmo_busy_after", 64'(o_busy), 64'd0);
    check("tmo_err_count", 64'(o_err_count), 64'd4);

    // Strobe on the cycle the timeout would fire is taken as data.
    send(8'hA5);
    send(8'h10);
    repeat (15) @(posedge clk);
    #1;
    send(8'h00);
    check("late_busy", 64'(o_busy), 64'd1);
    send(8'h10);
    check("late_valid", 64'(o_cmd_valid), 64'd1);
    check("late_id", 64'(o_cmd_id), 64'h10);
    check("late_tmo_count", 64'(cnt_tmo), 64'd1);
    check("late_err_count", 64'(o_err_count), 64'd4);

    // Saturation of the error counter.
    base = cnt_ck;
    for (int k = 0; k < 300; k++) send_frame(96'h00_00_10_A5, 4);
    @(negedge clk);
    #1;
    check("sat_err_count", 64'(o_err_count), 64'd255);
    check("sat_cksum_pulses", 64'(cnt_ck - base), 64'd300);
    check("sat_id_held", 64'(o_cmd_id), 64'h10);
    check("sat_len_held", 64'(o_cmd_len), 64'd0);
    @(posedge clk);
    #1;

    // Reset mid-frame with a coinciding strobe.
    send_frame(96'h01_02_10_A5, 4);
    check("mid_busy", 64'(o_busy), 64'd1);
    base = cnt_ck + cnt_len + cnt_tmo;
    rst = 1'b1;
    i_rx_valid = 1'b1;
    i_rx_data  = 8'hA5;
    @(posedge clk);
    #1;
    rst = 1'b0;
    i_rx_valid = 1'b0;
    check("rst2_busy", 64'(o_busy), 64'd0);
    check("rst2_id", 64'(o_cmd_id), 64'd0);
    check("rst2_payload", o_cmd_payload, 64'd0);
    check("rst2_err_count", 64'(o_err_count), 64'd0);
    repeat (20) @(posedge clk);
    #1;
    check("rst2_busy_later", 64'(o_busy), 64'd0);
    check("rst2_no_err_pulse", 64'(cnt_ck + cnt_len + cnt_tmo), 64'(base));
    send_frame(96'h15_02_01_02_10_A5, 6);
    check("post_rst_valid", 64'(o_cmd_valid), 64'd1);
    check("post_rst_id", 64'(o_cmd_id), 64'h10);
    check("post_rst_len", 64'(o_cmd_len), 64'd2);
    check("post_rst_payload", o_cmd_payload, 64'h0201);
    check("post_rst_err_count", 64'(o_err_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, SHALL be the frame start marker.
REQ-002 Parameter MAX_LEN, default 8, SHALL be the largest legal payload length in bytes (maximum 8).
REQ-003 Parameter TIMEOUT_CLKS, default 10000, SHALL be the maximum inter-byte gap, in clk cycles, inside a frame.
REQ-004 clk  input  1  SHALL be the single clock; all logic on rising edge.
REQ-005 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 i_rx_valid  input  1  SHALL be a one-cycle strobe marking a received byte.
REQ-007 i_rx_data  input  8  SHALL be the received byte, valid when i_rx_valid=1.
REQ-008 o_cmd_valid  output  1  SHALL be a one-cycle pulse marking a good frame.
REQ-009 o_cmd_id  output  8  SHALL be the ID of the last good frame.
REQ-010 o_cmd_len  output  4  SHALL be the LEN of the last good frame.
REQ-011 o_cmd_payload  output  64  SHALL be the payload of the last good frame; byte k at bits [8k+7:8k].
REQ-012 o_cksum_err  output  1  SHALL be a one-cycle pulse on checksum mismatch.
REQ-013 o_len_err  output  1  SHALL be a one-cycle pulse on LEN > MAX_LEN.
REQ-014 o_timeout_err  output  1  SHALL be a one-cycle pulse on inter-byte timeout.
REQ-015 o_err_count  output  8  SHALL be the saturating count of all errors.
REQ-016 o_busy  output  1  SHALL be 1 whenever state is not IDLE.

Function
REQ-017 Frame format SHALL be: SYNC_BYTE, ID, LEN, LEN payload bytes, CKSUM.
REQ-018 CKSUM SHALL equal (ID + LEN + sum of payload bytes) mod 256.
REQ-019 States SHALL be IDLE, GET_ID, GET_LEN, GET_PAYLOAD, GET_CKSUM; a byte advances state only when i_rx_valid=1.
REQ-020 IDLE: a byte equal to SYNC_BYTE SHALL go to GET_ID; any other byte SHALL be discarded with no error.
REQ-021 GET_ID: the byte SHALL be latched as ID; go to GET_LEN.
REQ-022 GET_LEN: LEN > MAX_LEN SHALL pulse o_len_err and go to IDLE; LEN = 0 SHALL go to GET_CKSUM; otherwise go to GET_PAYLOAD.
REQ-023 GET_PAYLOAD: bytes SHALL be stored at index 0..LEN-1; after byte LEN-1, go to GET_CKSUM.
REQ-024 Shadow payload bytes at index >= LEN SHALL be zero when published.
REQ-025 GET_CKSUM on match: the shadow ID/LEN/payload SHALL be copied to o_cmd_* and o_cmd_valid pulsed in the cycle after the CKSUM strobe; go to IDLE.
REQ-026 GET_CKSUM on mismatch: o_cksum_err SHALL pulse one cycle after the strobe; o_cmd_* SHALL be left unchanged; go to IDLE.
REQ-027 o_cmd_id, o_cmd_len and o_cmd_payload SHALL change only on a good frame and hold otherwise.
REQ-028 The gap counter SHALL clear on every i_rx_valid and in IDLE, and increment otherwise.
REQ-029 When the gap counter reaches TIMEOUT_CLKS-1 outside IDLE with no strobe, o_timeout_err SHALL pulse and the state SHALL go to IDLE.
REQ-030 A strobe in the same cycle the timeout would fire SHALL be processed as a byte; no timeout.
REQ-031 A SYNC_BYTE value received mid-frame SHALL be treated as data, with no resync.
REQ-032 The parser SHALL be back in IDLE one cycle after the final byte, so a strobe in the next cycle is accepted with no byte lost.
REQ-033 o_err_count SHALL increment by 1 on each error pulse and saturate at 255.
REQ-034 At most one error pulse SHALL occur per cycle.

Reset
REQ-035 When rst=1, the state SHALL go to IDLE and the gap counter, shadow registers and all outputs SHALL be cleared (o_cmd_payload=0, o_err_count=0, all pulses 0, o_busy=0).
REQ-036 Reset mid-frame SHALL abandon the frame with no error pulse; a strobe coinciding with rst SHALL be ignored.

Verification
REQ-037 Good frame: A5 10 02 01 02 15 -> o_cmd_valid=1 one cycle after the 0x15 strobe; id=0x10, len=2, payload=64'h0201; o_err_count=0.
REQ-038 LEN=0 frame: A5 20 00 20 -> o_cmd_valid=1; payload=0; then a bad frame A5 10 01 FF 00 -> o_cksum_err=1, o_err_count=1, outputs still id=0x20.
REQ-039 Length error: A5 10 09 -> o_len_err=1, o_busy=0 next cycle; the following A5 30 00 30 is accepted.
REQ-040 Timeout (TIMEOUT_CLKS=16): A5 10 then 16 idle cycles -> o_timeout_err=1 exactly once; a strobe at cycle 15 of a repeat -> no timeout.
REQ-041 Noise and saturation: bytes 00 FF 5A in IDLE -> no pulses; 300 bad-checksum frames -> o_err_count=255.
REQ-042 Reset: rst asserted after A5 10 02 01 -> o_busy=0 and all outputs cleared; A5 10 02 01 02 15 then decodes correctly.
